// File: rtl/demux2_pkg.sv
// Shared types and helpers for the two-channel TDM demultiplexer.
// Imported by the top level and the per-channel shift register.
package demux2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // Bits needed to index every slot of a 2*width-slot frame.
    function automatic int slot_w(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/demux2_tdm_chan_shift.sv
// LSB-first shift register for one channel of the TDM frame.
// word_o shows the contents as they will be after the current edge.
module chan_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             d_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    // New bits enter at the MSB so the first bit ends up in bit 0.
    always_comb begin
        sh_d = sh_q;
        if (en_i) begin
            sh_d = {d_i, sh_q[WIDTH-1:1]};
        end
    end

    // Register the shift contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign word_o = sh_d;

endmodule

// File: rtl/demux2_tdm.sv
// Two-channel TDM demultiplexer: slot tracking from a frame-start
// marker, per-channel deserialisation and a valid/ready output stage.
module demux2_tdm
    import demux2_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             frame_start,
    output logic             sel,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    localparam int CW = slot_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q0_q;
    logic [WIDTH-1:0] q1_q;
    logic             valid_q;
    logic             overrun_q;

    logic             in_recv;
    logic             odd_slot;
    logic             done;
    logic             en0;
    logic             en1;
    logic [WIDTH-1:0] word0;
    logic [WIDTH-1:0] word1;

    assign in_recv  = (state_q == RECV);
    assign odd_slot = cnt_q[0];

    // A frame completes when the last ch1 slot is captured undisturbed.
    assign done = in_recv && !frame_start && (cnt_q == LAST);

    // A frame_start cycle always carries ch0 bit 0.
    assign en0 = frame_start || (in_recv && !odd_slot);
    assign en1 = !frame_start && in_recv && odd_slot;

    assign sel = en1;

    chan_shift #(.WIDTH(WIDTH)) u_ch0 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en0),
        .d_i    (din),
        .word_o (word0)
    );

    chan_shift #(.WIDTH(WIDTH)) u_ch1 (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en1),
        .d_i    (din),
        .word_o (word1)
    );

    // Slot-tracking FSM: restart on frame_start, count through the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (frame_start) begin
            state_q <= RECV;
            cnt_q   <= CW'(1);
        end else if (in_recv) begin
            if (cnt_q == LAST) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Output stage: load on completion unless a held frame blocks it.
    always_ff @(posedge clk) begin
        if (rst) begin
            q0_q      <= '0;
            q1_q      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (done) begin
            if (!valid_q || ready) begin
                q0_q    <= word0;
                q1_q    <= word1;
                valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_q <= 1'b0;
        end
    end

    assign q0      = q0_q;
    assign q1      = q1_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_demux2_tdm.sv
// Self-checking bench for demux2_tdm (WIDTH=4) with a frame-level
// reference model and directed scenarios.
module tb_demux2_tdm;

    localparam int W = 4;
    localparam int SLOTS = 2 * W;

    logic         clk;
    logic         rst;
    logic         din;
    logic         frame_start;
    logic         sel;
    logic [W-1:0] q0;
    logic [W-1:0] q1;
    logic         valid;
    logic         ready;
    logic         overrun;

    int n_cmp;
    int n_bad;

    demux2_tdm #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .frame_start (frame_start),
        .sel         (sel),
        .q0          (q0),
        .q1          (q1),
        .valid       (valid),
        .ready       (ready),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: collect the interleaved stream, split it at the end.
    bit           m_active;
    bit           m_bits[$];
    bit           m_valid;
    bit [W-1:0]   m_q0;
    bit [W-1:0]   m_q1;
    bit           m_ovr;

    always @(posedge clk) begin
        bit         fin;
        bit [W-1:0] w0;
        bit [W-1:0] w1;
        fin = 1'b0;
        w0  = '0;
        w1  = '0;
        if (rst) begin
            m_active = 1'b0;
            m_bits.delete();
            m_valid  = 1'b0;
            m_q0     = '0;
            m_q1     = '0;
            m_ovr    = 1'b0;
        end else begin
            if (frame_start) begin
                m_bits.delete();
                m_bits.push_back(din);
                m_active = 1'b1;
            end else if (m_active) begin
                m_bits.push_back(din);
                if (m_bits.size() == SLOTS) begin
                    for (int k = 0; k < SLOTS; k++) begin
                        if (k % 2 == 0) w0[k/2] = m_bits[k];
                        else            w1[k/2] = m_bits[k];
                    end
                    fin = 1'b1;
                    m_active = 1'b0;
                    m_bits.delete();
                end
            end
            if (fin) begin
                if (!m_valid || ready) begin
                    m_q0    = w0;
                    m_q1    = w1;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Every cycle: compare all outputs with the model, away from the edge.
    always @(negedge clk) begin
        bit e_sel;
        e_sel = m_active && !frame_start && (m_bits.size() % 2 == 1);
        chk("sel",     32'(sel),     32'(e_sel));
        chk("valid",   32'(valid),   32'(m_valid));
        chk("q0",      32'(q0),      32'(m_q0));
        chk("q1",      32'(q1),      32'(m_q1));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    end

    logic sel_seen;

    task automatic drive(input logic d, input logic fs,
                         input logic r, input logic rs);
        din         = d;
        frame_start = fs;
        ready       = r;
        rst         = rs;
        #1 sel_seen = sel;
        @(posedge clk);
        #2;
    endtask

    logic [SLOTS-1:0] sel_hist;

    task automatic send_frame(input logic [W-1:0] w0,
                              input logic [W-1:0] w1,
                              input logic r, input logic r_last);
        for (int k = 0; k < SLOTS; k++) begin
            logic b;
            b = (k % 2 == 0) ? w0[k/2] : w1[k/2];
            drive(b, k == 0, (k == SLOTS - 1) ? r_last : r, 1'b0);
            sel_hist[k] = sel_seen;
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        din         = 1'b0;
        frame_start = 1'b0;
        ready       = 1'b0;
        rst         = 1'b1;
        @(posedge clk);
        #2;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid",   32'(valid),   32'd0);
        chk("reset_q0",      32'(q0),      32'd0);
        chk("reset_q1",      32'(q1),      32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);

        // Basic frame: din 0,1,1,1,0,0,1,0 -> ch0=0xA, ch1=0x3.
        send_frame(4'hA, 4'h3, 1'b0, 1'b0);
        chk("basic_sel_pattern", 32'(sel_hist), 32'hAA);
        chk("basic_valid", 32'(valid), 32'd1);
        chk("basic_q0",    32'(q0),    32'hA);
        chk("basic_q1",    32'(q1),    32'h3);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("basic_hold_q0", 32'(q0), 32'hA);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_drop_valid", 32'(valid), 32'd0);
        chk("basic_keep_q1",    32'(q1),    32'h3);

        // Back-to-back with ready high throughout.
        send_frame(4'hA, 4'h3, 1'b1, 1'b1);
        chk("b2b_first_q0", 32'(q0), 32'hA);
        send_frame(4'h5, 4'hC, 1'b1, 1'b1);
        chk("b2b_second_q0", 32'(q0),      32'h5);
        chk("b2b_second_q1", 32'(q1),      32'hC);
        chk("b2b_overrun",   32'(overrun), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b_drain", 32'(valid), 32'd0);

        // Overrun: two frames with ready low.
        send_frame(4'hA, 4'h3, 1'b0, 1'b0);
        send_frame(4'h5, 4'hC, 1'b0, 1'b0);
        chk("ovr_q0",   32'(q0),      32'hA);
        chk("ovr_q1",   32'(q1),      32'h3);
        chk("ovr_flag", 32'(overrun), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Restart: three bits of an aborted frame, then a full frame.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("restart_no_valid", 32'(valid), 32'd0);
        send_frame(4'h5, 4'hC, 1'b0, 1'b0);
        chk("restart_q0", 32'(q0), 32'h5);
        chk("restart_q1", 32'(q1), 32'hC);
        drive(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame, then din activity with no frame_start.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("midrst_q0",    32'(q0),    32'd0);
        chk("midrst_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 10; i++) drive(1'(i % 2), 1'b0, 1'b0, 1'b0);
        chk("midrst_quiet", 32'(valid), 32'd0);

        // Completion while a held frame is consumed in the same cycle.
        send_frame(4'hA, 4'h3, 1'b0, 1'b0);
        send_frame(4'h5, 4'hC, 1'b0, 1'b1);
        chk("swap_valid",   32'(valid),   32'd1);
        chk("swap_q0",      32'(q0),      32'h5);
        chk("swap_q1",      32'(q1),      32'hC);
        chk("swap_overrun", 32'(overrun), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
